// File: rtl/io_port_arbiter.sv
// io_port_arbiter: two-master arbiter/sequencer for the single IO peripheral port.
// Master 0 is the CPU load/store path; master 1 is a secondary requester.
// Each transaction walks IDLE -> ACCESS -> RESP, so one access is in flight at a time.
// Masters alternate round-robin when both request.
// Optional feature macro: IO_ARB_LOCK_EN. When defined, a master that holds m_lock
// can keep winning back-to-back grants, up to MAX_LOCK in a row.
//
// Handshake: a master raises m_req and holds we/addr/wdata stable until it sees its
// m_ack bit. The transfer completes on the clock edge where req & ack are both high.
// The command is sampled only in IDLE, so later changes have no effect on the access.
module io_port_arbiter #(
    parameter int ADDR_W   = 2,
    parameter int WDATA_W  = 12,
    parameter int RDATA_W  = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           m_req,
    input  logic [1:0]           m_we,
    input  logic [2*ADDR_W-1:0]  m_addr,
    input  logic [2*WDATA_W-1:0] m_wdata,
    input  logic [1:0]           m_lock,
    output logic [1:0]           m_ack,
    output logic [RDATA_W-1:0]   m_rdata,
    output logic                 busy,
    output logic                 pRead,
    output logic                 pWrite,
    output logic [ADDR_W-1:0]    addr,
    output logic [WDATA_W-1:0]   pWriteData,
    input  logic [RDATA_W-1:0]   pReadData
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_last;      // master granted most recently
    logic                 r_cmd_id;
    logic                 r_cmd_we;
    logic                 r_pread;
    logic                 r_pwrite;
    logic [ADDR_W-1:0]    r_addr;
    logic [WDATA_W-1:0]   r_pwdata;
    logic [RDATA_W-1:0]   r_rdata;

    logic                 w_grant;
    logic                 w_win;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [WDATA_W-1:0]   w_sel_wdata;

`ifdef IO_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    logic [CNT_W-1:0]     r_lock_cnt;
    logic                 w_lock_hold;
`else
    logic                 w_unused_lock;
    assign w_unused_lock = (^m_lock) ^ (MAX_LOCK > 0);
`endif

    assign w_grant = (r_state == S_IDLE) && (m_req != 2'b00);

    // Winner selection: a lone requester wins, a tie goes to the master that did not win last.
    always_comb begin
        w_win = (&m_req) ? ~r_last : m_req[1];
`ifdef IO_ARB_LOCK_EN
        w_lock_hold = m_req[r_last] & m_lock[r_last] & (r_lock_cnt < CNT_W'(MAX_LOCK));
        if (w_lock_hold) begin
            w_win = r_last;
        end
`endif
    end

    assign w_sel_we    = w_win ? m_we[1] : m_we[0];
    assign w_sel_addr  = w_win ? m_addr[ADDR_W +: ADDR_W] : m_addr[0 +: ADDR_W];
    assign w_sel_wdata = w_win ? m_wdata[WDATA_W +: WDATA_W] : m_wdata[0 +: WDATA_W];

    // State register; reset aborts any transaction without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: fixed three-cycle walk once a request is accepted.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_grant ? S_ACCESS : S_IDLE;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Command latch and IO strobes: loaded on the accept edge, live only during ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_id <= 1'b0;
            r_cmd_we <= 1'b0;
            r_pread  <= 1'b0;
            r_pwrite <= 1'b0;
            r_addr   <= '0;
            r_pwdata <= '0;
        end else if (w_grant) begin
            r_cmd_id <= w_win;
            r_cmd_we <= w_sel_we;
            r_pread  <= ~w_sel_we;
            r_pwrite <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_pwdata <= w_sel_wdata;
        end else begin
            r_pread  <= 1'b0;
            r_pwrite <= 1'b0;
            r_addr   <= '0;
            r_pwdata <= '0;
        end
    end

    // Read data capture at the end of ACCESS; writes leave zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (r_state == S_ACCESS) begin
            r_rdata <= r_cmd_we ? '0 : pReadData;
        end
    end

    // Round-robin pointer moves when the response is delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (r_state == S_RESP) begin
            r_last <= r_cmd_id;
        end
    end

`ifdef IO_ARB_LOCK_EN
    // Lock run length: counts consecutive locked grants to the same master, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_cnt <= '0;
        end else if (w_grant) begin
            if (!m_lock[w_win]) begin
                r_lock_cnt <= '0;
            end else if (w_win != r_last) begin
                r_lock_cnt <= CNT_W'(1);
            end else if (r_lock_cnt != CNT_W'(MAX_LOCK)) begin
                r_lock_cnt <= r_lock_cnt + CNT_W'(1);
            end
        end
    end
`endif

    assign busy       = (r_state != S_IDLE);
    assign pRead      = r_pread;
    assign pWrite     = r_pwrite;
    assign addr       = r_addr;
    assign pWriteData = r_pwdata;
    assign m_ack      = (r_state == S_RESP) ? (r_cmd_id ? 2'b10 : 2'b01) : 2'b00;
    assign m_rdata    = (r_state == S_RESP) ? r_rdata : '0;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Testbench for io_port_arbiter: directed transactions from both masters, a small IO
// register model answering reads, and a scoreboard checking every IO strobe cycle and ack.
module tb_io_port_arbiter;

    localparam int ADDR_W   = 2;
    localparam int WDATA_W  = 12;
    localparam int RDATA_W  = 32;
    localparam int MAX_LOCK = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT hookup ----------------
    logic req0, req1, we0, we1, lock0, lock1;
    logic [ADDR_W-1:0]  a0, a1;
    logic [WDATA_W-1:0] d0, d1;

    logic [1:0]           m_req, m_we, m_lock, m_ack;
    logic [2*ADDR_W-1:0]  m_addr;
    logic [2*WDATA_W-1:0] m_wdata;
    logic [RDATA_W-1:0]   m_rdata, pReadData;
    logic                 busy, pRead, pWrite;
    logic [ADDR_W-1:0]    addr;
    logic [WDATA_W-1:0]   pWriteData;

    assign m_req   = {req1, req0};
    assign m_we    = {we1, we0};
    assign m_lock  = {lock1, lock0};
    assign m_addr  = {a1, a0};
    assign m_wdata = {d1, d0};

    logic [31:0] io_regs [4];
    assign pReadData = pRead ? io_regs[addr] : 32'h0;

    io_port_arbiter #(
        .ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_lock(m_lock),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy),
        .pRead(pRead), .pWrite(pWrite), .addr(addr), .pWriteData(pWriteData),
        .pReadData(pReadData)
    );

    // ---------------- scoreboard ----------------
    logic [14:0] exp_io_q[$];   // {we, addr, wdata}
    logic [32:0] exp_q[$];      // {master id, rdata}
    int ack_cyc_q[$];
    int io_cyc_q[$];
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [14:0] io_e(input logic we, input logic [1:0] a, input logic [11:0] d);
        return {we, a, d};
    endfunction

    function automatic logic [32:0] ack_e(input logic id, input logic [31:0] rd);
        return {id, rd};
    endfunction

    logic [14:0] mon_io;
    logic [32:0] mon_ack;

    // monitor: compare every strobe cycle and every ack against the expected queues
    always @(negedge clk) begin
        if (pRead || pWrite) begin
            io_cyc_q.push_back(cyc);
            if (exp_io_q.size() == 0) begin
                chk("io_unexpected", 64'({pRead, pWrite, addr, pWriteData}), 64'(0));
            end else begin
                mon_io = exp_io_q.pop_front();
                chk("io_cmd", 64'({pRead, pWrite, addr, pWriteData}),
                    64'({~mon_io[14], mon_io[14], mon_io[13:12], mon_io[11:0]}));
            end
        end
        if (m_ack != 2'b00) begin
            ack_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", 64'({m_ack, m_rdata}), 64'(0));
            end else begin
                mon_ack = exp_q.pop_front();
                chk("ack", 64'({m_ack, m_rdata}),
                    64'({(mon_ack[32] ? 2'b10 : 2'b01), mon_ack[31:0]}));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the ack edge.
    task automatic txn(input int id, input logic we, input logic [1:0] a, input logic [11:0] d,
                       input bit keep);
        bit got;
        got = 1'b0;
        if (id == 0) begin req0 = 1'b1; we0 = we; a0 = a; d0 = d; end
        else         begin req1 = 1'b1; we1 = we; a1 = a; d1 = d; end
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            got = m_ack[id];
        end
        if (!got) begin
            n_total++;
            $display("FAIL txn_timeout m%0d: no ack within 40 cycles, ack required", id);
        end
        @(posedge clk); #1;
        if (!keep) begin
            if (id == 0) req0 = 1'b0;
            else         req1 = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, finish required");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    int t0, lat, g1, g2, g3;
    bit seen;

    initial begin
        reset = 1'b1;
        {req0, req1, we0, we1, lock0, lock1} = '0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        io_regs[0] = 32'h0000_0011;
        io_regs[1] = 32'h0000_0F00;
        io_regs[2] = 32'hDEAD_BEEF;
        io_regs[3] = 32'h0000_00A5;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",     64'(m_ack), 64'(0));
        chk("rst_rdata",   64'(m_rdata), 64'(0));
        chk("rst_busy",    64'(busy), 64'(0));
        chk("rst_strobes", 64'({pRead, pWrite}), 64'(0));
        chk("rst_addr_wd", 64'({addr, pWriteData}), 64'(0));
        @(posedge clk); #1 reset = 1'b0;

        // m0 read addr 3 -> A5, latency check
        ack_cyc_q.delete(); io_cyc_q.delete();
        exp_io_q.push_back(io_e(1'b0, 2'd3, 12'h000));
        exp_q.push_back(ack_e(1'b0, 32'h0000_00A5));
        t0 = cyc;
        txn(0, 1'b0, 2'd3, 12'h000, 1'b0);
        lat = (io_cyc_q.size() > 0) ? io_cyc_q[0] - t0 : -1;
        chk("t1_strobe_latency", 64'(lat), 64'(1));
        lat = (ack_cyc_q.size() > 0) ? ack_cyc_q[0] - t0 : -1;
        chk("t1_ack_latency", 64'(lat), 64'(2));

        // m1 write addr 1 = 3C0
        exp_io_q.push_back(io_e(1'b1, 2'd1, 12'h3C0));
        exp_q.push_back(ack_e(1'b1, 32'h0));
        txn(1, 1'b1, 2'd1, 12'h3C0, 1'b0);

        // m0 write to status (invalid op, issued unchanged)
        exp_io_q.push_back(io_e(1'b1, 2'd0, 12'h555));
        exp_q.push_back(ack_e(1'b0, 32'h0));
        txn(0, 1'b1, 2'd0, 12'h555, 1'b0);

        // both request continuously after reset: m0,m1,m0,m1, acks 3 cycles apart
        do_reset();
        ack_cyc_q.delete();
        exp_io_q.push_back(io_e(1'b0, 2'd0, 12'h000));
        exp_io_q.push_back(io_e(1'b0, 2'd2, 12'h000));
        exp_io_q.push_back(io_e(1'b1, 2'd1, 12'hABC));
        exp_io_q.push_back(io_e(1'b0, 2'd3, 12'h000));
        exp_q.push_back(ack_e(1'b0, 32'h0000_0011));
        exp_q.push_back(ack_e(1'b1, 32'hDEAD_BEEF));
        exp_q.push_back(ack_e(1'b0, 32'h0));
        exp_q.push_back(ack_e(1'b1, 32'h0000_00A5));
        fork
            begin txn(0, 1'b0, 2'd0, 12'h000, 1'b1); txn(0, 1'b1, 2'd1, 12'hABC, 1'b0); end
            begin txn(1, 1'b0, 2'd2, 12'h000, 1'b1); txn(1, 1'b0, 2'd3, 12'h000, 1'b0); end
        join
        g1 = (ack_cyc_q.size() == 4) ? ack_cyc_q[1] - ack_cyc_q[0] : -1;
        g2 = (ack_cyc_q.size() == 4) ? ack_cyc_q[2] - ack_cyc_q[1] : -1;
        g3 = (ack_cyc_q.size() == 4) ? ack_cyc_q[3] - ack_cyc_q[2] : -1;
        chk("b2b_gap1", 64'(g1), 64'(3));
        chk("b2b_gap2", 64'(g2), 64'(3));
        chk("b2b_gap3", 64'(g3), 64'(3));

        // master changes its command after the grant: issued access keeps sampled values
        exp_io_q.push_back(io_e(1'b0, 2'd3, 12'h000));
        exp_q.push_back(ack_e(1'b0, 32'h0000_00A5));
        fork
            txn(0, 1'b0, 2'd3, 12'h000, 1'b0);
            begin @(posedge clk); #2; a0 = 2'd0; d0 = 12'hFFF; we0 = 1'b1; end
        join
        we0 = 1'b0;

        // reset during ACCESS aborts with no ack
        exp_io_q.push_back(io_e(1'b0, 2'd1, 12'h000));
        req0 = 1'b1; we0 = 1'b0; a0 = 2'd1; d0 = 12'h000;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = pRead;
        end
        if (!seen) begin
            n_total++;
            $display("FAIL abort_wait: pRead never seen, pRead required");
        end
        reset = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("abort_busy",    64'(busy), 64'(0));
        chk("abort_strobes", 64'({pRead, pWrite}), 64'(0));
        chk("abort_addr_wd", 64'({addr, pWriteData}), 64'(0));
        chk("abort_ack",     64'({m_ack, m_rdata}), 64'(0));
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        exp_io_q.push_back(io_e(1'b0, 2'd2, 12'h000));
        exp_q.push_back(ack_e(1'b1, 32'hDEAD_BEEF));
        txn(1, 1'b0, 2'd2, 12'h000, 1'b0);

`ifdef IO_ARB_LOCK_EN
        // m0 locked continuously with m1 waiting: four m0 grants, then m1, then m0
        do_reset();
        lock0 = 1'b1; lock1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_io_q.push_back(io_e(1'b0, 2'd3, 12'h000));
            exp_q.push_back(ack_e(1'b0, 32'h0000_00A5));
        end
        exp_io_q.push_back(io_e(1'b1, 2'd1, 12'h0F0));
        exp_q.push_back(ack_e(1'b1, 32'h0));
        exp_io_q.push_back(io_e(1'b0, 2'd3, 12'h000));
        exp_q.push_back(ack_e(1'b0, 32'h0000_00A5));
        fork
            begin
                for (int k = 0; k < 5; k++) txn(0, 1'b0, 2'd3, 12'h000, (k < 4));
            end
            txn(1, 1'b1, 2'd1, 12'h0F0, 1'b0);
        join
        lock0 = 1'b0;
`else
        // lock inputs are ignored: round-robin continues to alternate
        do_reset();
        lock0 = 1'b1; lock1 = 1'b1;
        exp_io_q.push_back(io_e(1'b0, 2'd3, 12'h000));
        exp_io_q.push_back(io_e(1'b0, 2'd0, 12'h000));
        exp_io_q.push_back(io_e(1'b0, 2'd2, 12'h000));
        exp_q.push_back(ack_e(1'b0, 32'h0000_00A5));
        exp_q.push_back(ack_e(1'b1, 32'h0000_0011));
        exp_q.push_back(ack_e(1'b0, 32'hDEAD_BEEF));
        fork
            begin txn(0, 1'b0, 2'd3, 12'h000, 1'b1); txn(0, 1'b0, 2'd2, 12'h000, 1'b0); end
            txn(1, 1'b0, 2'd0, 12'h000, 1'b0);
        join
        lock0 = 1'b0; lock1 = 1'b0;
`endif

        // drain and final report
        repeat (5) @(negedge clk);
        chk("exp_io_q_empty", 64'(exp_io_q.size()), 64'(0));
        chk("exp_q_empty",    64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
